// File: rtl/regfile_port_ctrl.sv
// Regfile port sequencer: one-outstanding read with write bypass,
// plus round-robin arbitration of the single write port between A and B.
module regfile_port_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [4:0]       rd_req_rs1,
    input  logic [4:0]       rd_req_rs2,
    output logic             rd_rsp_valid,
    input  logic             rd_rsp_ready,
    output logic [XLEN-1:0]  rd_rsp_rs1_d,
    output logic [XLEN-1:0]  rd_rsp_rs2_d,
    input  logic             wa_valid,
    output logic             wa_ready,
    input  logic [4:0]       wa_rd,
    input  logic [XLEN-1:0]  wa_data,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [XLEN-1:0]  rf_rs1_d,
    input  logic [XLEN-1:0]  rf_rs2_d,
    output logic             rf_wr,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_rd_d,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t          state, state_nx;
    logic [4:0]      rs1_q, rs2_q;
    logic            byp1_q, byp2_q;
    logic [XLEN-1:0] byp1_d_q, byp2_d_q;
    logic            rr_q;
    logic            both, grant_a, grant_b, accept;

    // rr_q == 0 favours A on the next contended cycle
    assign both    = wa_valid & wb_valid;
    assign grant_a = ~rst & wa_valid & (~wb_valid | ~rr_q);
    assign grant_b = ~rst & wb_valid & (~wa_valid | rr_q);
    assign wa_ready = grant_a;
    assign wb_ready = grant_b;
    assign rf_rd    = grant_b ? wb_rd : wa_rd;
    assign rf_rd_d  = grant_b ? wb_data : wa_data;
    assign rf_wr    = (grant_a | grant_b) & (rf_rd != 5'd0);

    assign accept = rd_req_valid & rd_req_ready;

    always_comb begin
        state_nx     = state;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rf_rs1       = rs1_q;
        rf_rs2       = rs2_q;
        unique case (state)
            IDLE: begin
                rd_req_ready = ~rst;
                rf_rs1       = rd_req_rs1;
                rf_rs2       = rd_req_rs2;
                if (rd_req_valid) state_nx = READ;
            end
            READ: state_nx = RESP;
            RESP: begin
                rd_rsp_valid = 1'b1;
                if (rd_rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            byp1_q       <= 1'b0;
            byp2_q       <= 1'b0;
            byp1_d_q     <= '0;
            byp2_d_q     <= '0;
            rd_rsp_rs1_d <= '0;
            rd_rsp_rs2_d <= '0;
            rr_q         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rs1_q    <= rd_req_rs1;
                rs2_q    <= rd_req_rs2;
                byp1_q   <= rf_wr & (rf_rd == rd_req_rs1);
                byp2_q   <= rf_wr & (rf_rd == rd_req_rs2);
                byp1_d_q <= rf_rd_d;
                byp2_d_q <= rf_rd_d;
            end
            // regfile data for the accepted indices lands one cycle later
            if (state == READ) begin
                rd_rsp_rs1_d <= (rs1_q == 5'd0) ? '0 :
                                byp1_q ? byp1_d_q : rf_rs1_d;
                rd_rsp_rs2_d <= (rs2_q == 5'd0) ? '0 :
                                byp2_q ? byp2_d_q : rf_rs2_d;
            end
            if (both) begin
                rr_q <= ~rr_q;
                if (conflict_cnt != {CNT_W{1'b1}})
                    conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural 2R/1W regfile
// (synchronous read returning pre-write contents).
module tb_regfile_port_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rd_req_valid, rd_req_ready;
    logic [4:0]       rd_req_rs1, rd_req_rs2;
    logic             rd_rsp_valid, rd_rsp_ready;
    logic [XLEN-1:0]  rd_rsp_rs1_d, rd_rsp_rs2_d;
    logic             wa_valid, wa_ready, wb_valid, wb_ready;
    logic [4:0]       wa_rd, wb_rd;
    logic [XLEN-1:0]  wa_data, wb_data;
    logic [4:0]       rf_rs1, rf_rs2, rf_rd;
    logic [XLEN-1:0]  rf_rs1_d, rf_rs2_d, rf_rd_d;
    logic             rf_wr;
    logic [CNT_W-1:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] regs [32];

    always #5 clk = ~clk;

    regfile_port_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_rs1(rd_req_rs1), .rd_req_rs2(rd_req_rs2),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_rs1_d(rd_rsp_rs1_d), .rd_rsp_rs2_d(rd_rsp_rs2_d),
        .wa_valid(wa_valid), .wa_ready(wa_ready),
        .wa_rd(wa_rd), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_d(rf_rs1_d), .rf_rs2_d(rf_rs2_d),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_rd_d(rf_rd_d),
        .conflict_cnt(conflict_cnt)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_wr && rf_rd != 5'd0) begin
            regs[rf_rd] <= rf_rd_d;
        end
        rf_rs1_d <= rst ? '0 : regs[rf_rs1];
        rf_rs2_d <= rst ? '0 : regs[rf_rs2];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_txn(input logic [4:0] r1, input logic [4:0] r2,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input string nm);
        rd_req_valid = 1'b1;
        rd_req_rs1   = r1;
        rd_req_rs2   = r2;
        rd_rsp_ready = 1'b0;
        #1;
        chk({nm, "_req_ready"}, {31'd0, rd_req_ready}, 32'd1);
        step();
        rd_req_valid = 1'b0;
        step();
        chk({nm, "_rsp_valid"}, {31'd0, rd_rsp_valid}, 32'd1);
        chk({nm, "_rs1"}, rd_rsp_rs1_d, e1);
        chk({nm, "_rs2"}, rd_rsp_rs2_d, e2);
        rd_rsp_ready = 1'b1;
        step();
        rd_rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic        bv;
        logic [4:0]  brd;
        logic        e_ar;
        logic        e_br;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // uncontended, then four contended (A,B,A,B), then rr after mixes
        vecs[0]  = '{1, 1, 0, 2, 1, 0, 1, 1, 32'h100, 0};
        vecs[1]  = '{0, 1, 1, 2, 0, 1, 1, 2, 32'h201, 0};
        vecs[2]  = '{1, 1, 1, 2, 1, 0, 1, 1, 32'h102, 0};
        vecs[3]  = '{1, 1, 1, 2, 0, 1, 1, 2, 32'h203, 1};
        vecs[4]  = '{1, 1, 1, 2, 1, 0, 1, 1, 32'h104, 2};
        vecs[5]  = '{1, 1, 1, 2, 0, 1, 1, 2, 32'h205, 3};
        vecs[6]  = '{1, 3, 0, 4, 1, 0, 1, 3, 32'h106, 4};
        vecs[7]  = '{1, 3, 1, 4, 1, 0, 1, 3, 32'h107, 4};
        vecs[8]  = '{1, 3, 0, 4, 1, 0, 1, 3, 32'h108, 5};
        vecs[9]  = '{1, 3, 1, 4, 0, 1, 1, 4, 32'h209, 5};
        vecs[10] = '{0, 3, 1, 0, 0, 1, 0, 0, 32'h20a, 6};
        vecs[11] = '{0, 3, 0, 4, 0, 0, 0, 3, 32'h10b, 6};

        rst = 1'b1;
        rd_req_valid = 1'b0; rd_req_rs1 = '0; rd_req_rs2 = '0;
        rd_rsp_ready = 1'b0;
        wa_valid = 1'b1; wa_rd = 5'd3; wa_data = 32'h55;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h66;
        step();
        step();
        chk("rst_req_ready", {31'd0, rd_req_ready}, 32'd0);
        chk("rst_rf_wr", {31'd0, rf_wr}, 32'd0);
        chk("rst_wa_ready", {31'd0, wa_ready}, 32'd0);
        chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
        rst = 1'b0;
        wa_valid = 1'b0; wb_valid = 1'b0;
        #1;
        chk("init_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        chk("init_cnt", {28'd0, conflict_cnt}, 32'd0);
        chk("init_rs1_d", rd_rsp_rs1_d, 32'd0);

        // T1: preload x5, read with response held three cycles
        wa_valid = 1'b1; wa_rd = 5'd5; wa_data = 32'h1234;
        step();
        wa_valid = 1'b0;
        rd_req_valid = 1'b1; rd_req_rs1 = 5'd5; rd_req_rs2 = 5'd0;
        #1;
        chk("t1_req_ready", {31'd0, rd_req_ready}, 32'd1);
        step();
        rd_req_valid = 1'b0;
        chk("t1_n1_valid", {31'd0, rd_rsp_valid}, 32'd0);
        chk("t1_n1_ready", {31'd0, rd_req_ready}, 32'd0);
        step();
        chk("t1_n2_valid", {31'd0, rd_rsp_valid}, 32'd1);
        chk("t1_rs1", rd_rsp_rs1_d, 32'h1234);
        chk("t1_rs2", rd_rsp_rs2_d, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_hold_valid", {31'd0, rd_rsp_valid}, 32'd1);
            chk("t1_hold_rs1", rd_rsp_rs1_d, 32'h1234);
            chk("t1_hold_ready", {31'd0, rd_req_ready}, 32'd0);
        end
        rd_rsp_ready = 1'b1;
        step();
        rd_rsp_ready = 1'b0;
        chk("t1_done_valid", {31'd0, rd_rsp_valid}, 32'd0);

        // T2: bypass of a same-cycle write; later write not reflected
        rd_req_valid = 1'b1; rd_req_rs1 = 5'd7; rd_req_rs2 = 5'd7;
        wa_valid = 1'b1; wa_rd = 5'd7; wa_data = 32'hDEAD;
        step();
        rd_req_valid = 1'b0;
        wa_data = 32'hBEEF;
        step();
        wa_valid = 1'b0;
        chk("t2_valid", {31'd0, rd_rsp_valid}, 32'd1);
        chk("t2_rs1", rd_rsp_rs1_d, 32'hDEAD);
        chk("t2_rs2", rd_rsp_rs2_d, 32'hDEAD);
        rd_rsp_ready = 1'b1;
        step();
        rd_rsp_ready = 1'b0;
        read_txn(5'd7, 5'd0, 32'hBEEF, 32'h0, "t2_after");

        // T3/T4: arbiter table
        for (int i = 0; i < 12; i++) begin
            wa_valid = vecs[i].av; wa_rd = vecs[i].ard;
            wa_data  = 32'h100 + 32'(i);
            wb_valid = vecs[i].bv; wb_rd = vecs[i].brd;
            wb_data  = 32'h200 + 32'(i);
            #1;
            chk($sformatf("arb%0d_wa_ready", i), {31'd0, wa_ready},
                {31'd0, vecs[i].e_ar});
            chk($sformatf("arb%0d_wb_ready", i), {31'd0, wb_ready},
                {31'd0, vecs[i].e_br});
            chk($sformatf("arb%0d_rf_wr", i), {31'd0, rf_wr},
                {31'd0, vecs[i].e_wr});
            if (vecs[i].e_wr) begin
                chk($sformatf("arb%0d_rf_rd", i), {27'd0, rf_rd},
                    {27'd0, vecs[i].e_rd});
                chk($sformatf("arb%0d_rf_rd_d", i), rf_rd_d, vecs[i].e_d);
            end
            chk($sformatf("arb%0d_cnt", i), {28'd0, conflict_cnt},
                {28'd0, vecs[i].e_cnt});
            step();
        end
        wa_valid = 1'b0; wb_valid = 1'b0;
        read_txn(5'd1, 5'd2, 32'h104, 32'h205, "t3_x1x2");
        read_txn(5'd0, 5'd3, 32'h0, 32'h108, "t4_x0x3");
        read_txn(5'd4, 5'd0, 32'h209, 32'h0, "t4_x4");

        // T5: saturate counter (6 -> 15) then one more contended cycle
        wa_valid = 1'b1; wb_valid = 1'b1;
        wa_rd = 5'd8; wb_rd = 5'd9;
        for (int i = 0; i < 9; i++) step();
        chk("t5_cnt_max", {28'd0, conflict_cnt}, 32'd15);
        step();
        chk("t5_cnt_sat", {28'd0, conflict_cnt}, 32'd15);
        wa_valid = 1'b0; wb_valid = 1'b0;

        // T6: reset while in READ
        rd_req_valid = 1'b1; rd_req_rs1 = 5'd8; rd_req_rs2 = 5'd9;
        step();
        rd_req_valid = 1'b0;
        rst = 1'b1;
        wa_valid = 1'b1; wb_valid = 1'b1;
        #1;
        chk("t6_rst_wa_ready", {31'd0, wa_ready}, 32'd0);
        chk("t6_rst_wb_ready", {31'd0, wb_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        chk("t6_req_ready", {31'd0, rd_req_ready}, 32'd1);
        chk("t6_cnt", {28'd0, conflict_cnt}, 32'd0);
        chk("t6_rs1_d", rd_rsp_rs1_d, 32'd0);
        chk("t6_rr_a", {31'd0, wa_ready}, 32'd1);
        chk("t6_rr_b", {31'd0, wb_ready}, 32'd0);
        wa_valid = 1'b0; wb_valid = 1'b0;
        step();
        chk("t6_rsp_valid2", {31'd0, rd_rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
